hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 4, mult/div occupancy in cycles; legal range 2..16.
REQ-002 clk  in  1  pipeline clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ID_rs, ID_rt  in  5 each  source register indices of the instruction in ID.
REQ-005 ID_uses_rt  in  1  ID instruction reads rt as a source.
REQ-006 EX_memread, EX_rt  in  1, 5  the EX instruction is a load, and its destination register.
REQ-007 branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-008 md_start  in  1  a mult/div is issuing in EX this cycle.
REQ-009 pc_stall, ifid_stall  out  1 each  hold the PC and the IF/ID register.
REQ-010 ifid_flush, idex_flush  out  1 each  zero the IF/ID and ID/EX registers (bubble).
REQ-011 idex_stall, exmem_flush  out  1 each  hold ID/EX and insert a bubble into EX/MEM.
REQ-012 md_busy  out  1  high while in MD_WAIT.
REQ-013 stall_cycles  out  16  saturating count of cycles with pc_stall high.

Function
REQ-014 FSM states: RUN and MD_WAIT; a 4-bit down-counter md_cnt belongs to MD_WAIT.
REQ-015 Load-use hazard: EX_memread and EX_rt != 0 and (EX_rt == ID_rs, or ID_uses_rt and EX_rt == ID_rt).
REQ-016 RUN with a load-use hazard and no branch_taken: pc_stall=1, ifid_stall=1, idex_flush=1 in the same cycle (combinational), for exactly one cycle per hazard.
REQ-017 RUN with branch_taken: ifid_flush=1, idex_flush=1, pc_stall=0, ifid_stall=0; this overrides any load-use hazard (wrong-path instruction).
REQ-018 RUN with md_start: the next state is MD_WAIT and md_cnt loads MD_LAT-1; outputs this cycle follow REQ-016/017 only.
REQ-019 md_start and branch_taken in the same cycle: apply the branch flush and still enter MD_WAIT.
REQ-020 MD_WAIT: pc_stall=1, ifid_stall=1, idex_stall=1, exmem_flush=1, md_busy=1; ifid_flush and idex_flush are 0.
REQ-021 MD_WAIT ignores branch_taken, md_start and load-use inputs.
REQ-022 MD_WAIT: md_cnt decrements each cycle; at md_cnt == 1 the next state is RUN; total MD_WAIT residency is MD_LAT-1 cycles.
REQ-023 Flush and stall of the same register are never asserted together.
REQ-024 stall_cycles increments on each posedge where pc_stall=1, saturating at 16'hFFFF with no wrap.
REQ-025 All outputs not named as asserted in a given state/condition are 0.

Reset
REQ-026 rst_n low: state=RUN, md_cnt=0, stall_cycles=0, immediately and independent of clk.
REQ-027 While rst_n is low, all control outputs are 0 regardless of inputs.
REQ-028 Reset during MD_WAIT aborts the wait; the first cycle after deassertion is RUN.

Structure
REQ-029 The shared package mips_pkg holds the state enum (RUN, MD_WAIT), REG_IDX_W=5, and the MD_LAT default.
REQ-030 One combinational sub-module, ld_use_detect, implements REQ-015; the FSM, counters and output decode stay in hazard_ctrl.

Verification
REQ-031 Load-use: EX_memread=1, EX_rt=5, ID_rs=5 -> one cycle of pc_stall=ifid_stall=idex_flush=1; stall_cycles=1.
REQ-032 $zero and rt-use: EX_rt=0, ID_rs=0 -> no stall; EX_rt=7, ID_rt=7, ID_uses_rt=0 -> no stall; ID_uses_rt=1 -> stall.
REQ-033 Branch override: load-use hazard plus branch_taken=1 -> ifid_flush=idex_flush=1, pc_stall=0.
REQ-034 Mult/div: md_start with MD_LAT=4 -> next 3 cycles md_busy=pc_stall=idex_stall=exmem_flush=1, then RUN; branch_taken during the wait has no effect.
REQ-035 Reset in MD_WAIT: rst_n low mid-wait -> outputs 0 asynchronously, md_busy=0 after release, stall_cycles=0.
REQ-036 Saturation: force 65536+ stall cycles -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS pipeline control blocks.
//   hz_state_t     : hazard controller FSM states (RUN, MD_WAIT)
//   REG_IDX_W      : register index width
//   MD_LAT_DEFAULT : default mult/div occupancy in cycles (legal 2..16)
//   MD_CNT_W       : width of the mult/div wait down-counter
//   STALL_CNT_W    : width of the saturating stall-cycle counter
package mips_pkg;

  localparam int REG_IDX_W      = 5;
  localparam int MD_LAT_DEFAULT = 4;
  localparam int MD_CNT_W       = 4;
  localparam int STALL_CNT_W    = 16;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

endpackage : mips_pkg

// File: rtl/ld_use_detect.sv
// ld_use_detect -- combinational load-use hazard detector.
// A hazard exists when the EX instruction is a load writing a non-$zero
// register that the ID instruction reads (rs always, rt only when used).
// Ports:
//   EX_memread, EX_rt      : EX instruction is a load, and its destination
//   ID_rs, ID_rt           : ID instruction source indices
//   ID_uses_rt             : ID instruction reads rt
//   load_use               : hazard detected
module ld_use_detect
  import mips_pkg::*;
(
  input  logic                 EX_memread,
  input  logic [REG_IDX_W-1:0] EX_rt,
  input  logic [REG_IDX_W-1:0] ID_rs,
  input  logic [REG_IDX_W-1:0] ID_rt,
  input  logic                 ID_uses_rt,
  output logic                 load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (EX_rt == ID_rs);
  assign rt_match = ID_uses_rt && (EX_rt == ID_rt);

  // $zero is never a real dependency: writes to it are discarded.
  assign load_use = EX_memread && (EX_rt != '0) && (rs_match || rt_match);

endmodule : ld_use_detect

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller.
// Stalls IF/ID on load-use hazards, flushes wrong-path instructions on taken
// branches, and freezes the front of the pipeline while a multi-cycle
// mult/div occupies EX.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   ID_rs, ID_rt, ID_uses_rt    : ID stage source operands
//   EX_memread, EX_rt           : EX stage load and its destination
//   branch_taken                : branch/jump resolved taken in EX
//   md_start                    : mult/div issuing in EX
//   pc_stall, ifid_stall        : hold PC and IF/ID
//   ifid_flush, idex_flush      : bubble IF/ID and ID/EX
//   idex_stall, exmem_flush     : hold ID/EX, bubble EX/MEM
//   md_busy                     : mult/div wait in progress
//   stall_cycles                : saturating count of pc_stall cycles
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT  // legal range 2..16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_IDX_W-1:0]   ID_rs,
  input  logic [REG_IDX_W-1:0]   ID_rt,
  input  logic                   ID_uses_rt,
  input  logic                   EX_memread,
  input  logic [REG_IDX_W-1:0]   EX_rt,
  input  logic                   branch_taken,
  input  logic                   md_start,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   idex_stall,
  output logic                   exmem_flush,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // The issuing cycle itself is spent in RUN, so MD_WAIT covers the rest.
  localparam logic [MD_CNT_W-1:0] MD_CNT_LOAD = MD_CNT_W'(MD_LAT - 1);

  hz_state_t           state;
  logic [MD_CNT_W-1:0] md_cnt;
  logic                load_use;

  ld_use_detect u_ld_use_detect (
    .EX_memread (EX_memread),
    .EX_rt      (EX_rt),
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .ID_uses_rt (ID_uses_rt),
    .load_use   (load_use)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          // A branch in the same cycle only flushes younger instructions;
          // the mult/div itself is already in EX and still proceeds.
          if (md_start) begin
            state  <= MD_WAIT;
            md_cnt <= MD_CNT_LOAD;
          end
        end
        MD_WAIT: begin
          md_cnt <= md_cnt - 1'b1;
          if (md_cnt == MD_CNT_W'(1)) begin
            state <= RUN;
          end
        end
        default: begin
          state  <= RUN;
          md_cnt <= '0;
        end
      endcase
    end
  end

  // Output decode is combinational so load-use stalls and branch flushes
  // take effect in the same cycle the condition is seen.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    idex_stall  = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            // The ID instruction is wrong-path, so its hazard is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_flush = 1'b1;
          md_busy     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (pc_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl (MD_LAT=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge that updates state.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_uses_rt;
  logic        EX_memread;
  logic [4:0]  EX_rt;
  logic        branch_taken;
  logic        md_start;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic        idex_stall;
  logic        exmem_flush;
  logic        md_busy;
  logic [15:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  // {pc_stall, ifid_stall, ifid_flush, idex_flush, idex_stall, exmem_flush, md_busy}
  logic [6:0] outs;
  assign outs = {pc_stall, ifid_stall, ifid_flush, idex_flush,
                 idex_stall, exmem_flush, md_busy};

  localparam logic [6:0] O_NONE = 7'b000_0000;
  localparam logic [6:0] O_LU   = 7'b110_1000;
  localparam logic [6:0] O_BR   = 7'b001_1000;
  localparam logic [6:0] O_MD   = 7'b110_0111;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_uses_rt   (ID_uses_rt),
    .EX_memread   (EX_memread),
    .EX_rt        (EX_rt),
    .branch_taken (branch_taken),
    .md_start     (md_start),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .idex_stall   (idex_stall),
    .exmem_flush  (exmem_flush),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic memread, input logic [4:0] ex_rt,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt, input logic br, input logic md);
    EX_memread   = memread;
    EX_rt        = ex_rt;
    ID_rs        = rs;
    ID_rt        = rt;
    ID_uses_rt   = uses_rt;
    branch_taken = br;
    md_start     = md;
  endtask

  // Advance to the next falling edge, apply inputs, let logic settle.
  task automatic step(input logic memread, input logic [4:0] ex_rt,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses_rt, input logic br, input logic md);
    @(negedge clk);
    set_in(memread, ex_rt, rs, rt, uses_rt, br, md);
    #1;
  endtask

  initial begin
    // Reset held with hazard, branch and md_start all active: outputs stay 0.
    rst_n = 1'b0;
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
    #2;
    check("reset_outs", 16'(outs), 16'(O_NONE));
    check("reset_stall_cnt", stall_cycles, 16'h0000);
    @(posedge clk); #1;
    check("reset_after_edge", 16'(outs), 16'(O_NONE));

    // Release reset with idle inputs.
    @(negedge clk);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("idle_outs", 16'(outs), 16'(O_NONE));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("idle_run", 16'(outs), 16'(O_NONE));

    // Basic load-use on rs: one stall cycle, counter goes to 1.
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_rs", 16'(outs), 16'(O_LU));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_rs_release", 16'(outs), 16'(O_NONE));
    check("lu_rs_count", stall_cycles, 16'd1);

    // $zero destination never stalls.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("zero_reg", 16'(outs), 16'(O_NONE));
    // rt match only matters when rt is a source.
    step(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    check("rt_unused", 16'(outs), 16'(O_NONE));
    step(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    check("rt_used", 16'(outs), 16'(O_LU));
    // Not a load: matching index is harmless.
    step(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
    check("no_load", 16'(outs), 16'(O_NONE));
    check("rt_used_count", stall_cycles, 16'd2);

    // Branch overrides a load-use hazard.
    step(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
    check("branch_override", 16'(outs), 16'(O_BR));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("branch_plain", 16'(outs), 16'(O_BR));
    check("branch_no_count", stall_cycles, 16'd2);

    // md_start alone: issuing cycle has no stall, then 3 cycles of MD_WAIT
    // during which branch and load-use inputs are ignored.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("md_issue", 16'(outs), 16'(O_NONE));
    step(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1);
    check("md_wait1", 16'(outs), 16'(O_MD));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("md_wait2", 16'(outs), 16'(O_MD));
    step(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    check("md_wait3", 16'(outs), 16'(O_MD));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("md_done", 16'(outs), 16'(O_NONE));
    check("md_count", stall_cycles, 16'd5);

    // md_start with branch: flush now, still enter MD_WAIT.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("md_br_issue", 16'(outs), 16'(O_BR));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("md_br_wait1", 16'(outs), 16'(O_MD));
    check("md_br_count", stall_cycles, 16'd5);

    // Asynchronous reset in the middle of the wait.
    @(negedge clk);
    #1;
    check("md_br_wait2", 16'(outs), 16'(O_MD));
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 16'(outs), 16'(O_NONE));
    check("async_rst_count", stall_cycles, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release", 16'(outs), 16'(O_NONE));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rst_release_run", 16'(md_busy), 16'd0);
    check("rst_release_count", stall_cycles, 16'h0000);

    // Saturation: hold a load-use hazard so every edge counts.
    step(1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
    check("sat_start", stall_cycles, 16'h0000);
    repeat (65534) @(posedge clk);
    @(negedge clk); #1;
    check("sat_near", stall_cycles, 16'hFFFE);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("sat_hold", stall_cycles, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_ctrl
